// File: rtl/udp_rx_buf_pkg.sv
// Shared definitions for the UDP receive ping-pong packet buffer:
// write-FSM encoding, default bank geometry and counter widths.
package udp_rx_buf_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int WORD_W     = 32;
    localparam int LEN_W      = 16;
    localparam int PKT_CNT_W  = 32;
    localparam int DROP_CNT_W = 16;
    localparam int OVF_CNT_W  = 16;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

endpackage

// File: rtl/udp_buf_ram.sv
// Simple dual-port RAM holding both packet banks, addressed by {bank, word}.
// One write port, one registered read port; the read register clears on clr
// so the read data output starts at zero.
module udp_buf_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Write port: store the incoming payload word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; data appears one cycle after the address.
    always_ff @(posedge clk) begin
        if (clr) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/udp_rx_pkt_buffer.sv
// Ping-pong packet buffer behind the GMII UDP receiver. Payload words fill
// one bank at a time; a bank is committed only when the packet ends without
// overflow. Committed packets are read in arrival order through a random
// access port and freed with an explicit release.
module udp_rx_pkt_buffer
    import udp_rx_buf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [WORD_W-1:0]     in_word,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [LEN_W-1:0]      in_len,
    output logic                  pkt_avail,
    output logic [LEN_W-1:0]      pkt_len,
    output logic [ADDR_W:0]       pkt_words,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [WORD_W-1:0]     rd_data,
    input  logic                  pkt_release,
    output logic [PKT_CNT_W-1:0]  pkt_count,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic [OVF_CNT_W-1:0]  ovf_count,
    output logic                  busy
);

    localparam logic [ADDR_W:0] WCNT_FULL = (ADDR_W+1)'(DEPTH);

    wr_state_t         state;
    logic [ADDR_W:0]   wcnt;
    logic              wr_sel;
    logic              rd_sel;
    logic [1:0]        full;
    logic [LEN_W-1:0]  len_q   [2];
    logic [ADDR_W:0]   words_q [2];

    logic              ram_we;
    logic [ADDR_W-1:0] ram_word;

    // A word is stored when it opens a packet into a free bank or extends a
    // packet that still has room; everything else goes nowhere.
    always_comb begin
        ram_we   = 1'b0;
        ram_word = '0;
        if (in_valid) begin
            if (state == W_IDLE) begin
                ram_we   = !full[wr_sel];
                ram_word = '0;
            end else if (state == W_FILL) begin
                ram_we   = (wcnt != WCNT_FULL);
                ram_word = wcnt[ADDR_W-1:0];
            end
        end
    end

    udp_buf_ram #(
        .AW (ADDR_W + 1),
        .DW (WORD_W)
    ) u_ram (
        .clk   (clk),
        .clr   (clr),
        .we    (ram_we),
        .waddr ({wr_sel, ram_word}),
        .wdata (in_word),
        .raddr ({rd_sel, rd_addr}),
        .rdata (rd_data)
    );

    // Write FSM plus bank bookkeeping: commit, drop and overflow accounting,
    // and the read-side release that frees the head bank.
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= W_IDLE;
            wcnt       <= '0;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            full       <= '0;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            words_q[0] <= '0;
            words_q[1] <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
            ovf_count  <= '0;
        end else begin
            // Release only touches the head bank; a commit in the same cycle
            // always lands in the other bank, so both updates coexist.
            if (pkt_release && full[rd_sel]) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
            end

            case (state)
                W_IDLE: begin
                    if (in_valid) begin
                        if (!full[wr_sel]) begin
                            if (in_last) begin
                                full[wr_sel]    <= 1'b1;
                                len_q[wr_sel]   <= in_len;
                                words_q[wr_sel] <= (ADDR_W+1)'(1);
                                wr_sel          <= ~wr_sel;
                                pkt_count       <= pkt_count + PKT_CNT_W'(1);
                                wcnt            <= '0;
                            end else begin
                                wcnt  <= (ADDR_W+1)'(1);
                                state <= W_FILL;
                            end
                        end else begin
                            // Availability is decided here, at the first word only.
                            drop_count <= drop_count + DROP_CNT_W'(1);
                            if (!in_last) begin
                                state <= W_DROP;
                            end
                        end
                    end
                end

                W_FILL: begin
                    if (in_valid && (wcnt == WCNT_FULL)) begin
                        ovf_count <= ovf_count + OVF_CNT_W'(1);
                        wcnt      <= '0;
                        state     <= in_last ? W_IDLE : W_DROP;
                    end else begin
                        if (in_valid) begin
                            wcnt <= wcnt + (ADDR_W+1)'(1);
                        end
                        if (in_last) begin
                            full[wr_sel]    <= 1'b1;
                            len_q[wr_sel]   <= in_len;
                            words_q[wr_sel] <= wcnt + (ADDR_W+1)'(in_valid);
                            wr_sel          <= ~wr_sel;
                            pkt_count       <= pkt_count + PKT_CNT_W'(1);
                            wcnt            <= '0;
                            state           <= W_IDLE;
                        end
                    end
                end

                W_DROP: begin
                    if (in_last) begin
                        state <= W_IDLE;
                    end
                end

                default: begin
                    state <= W_IDLE;
                end
            endcase
        end
    end

    assign pkt_avail = full[rd_sel];
    assign pkt_len   = len_q[rd_sel];
    assign pkt_words = words_q[rd_sel];
    assign busy      = (state != W_IDLE);

endmodule

// File: tb/tb_udp_rx_pkt_buffer.sv
// Scoreboard bench for udp_rx_pkt_buffer: the driver pushes expected packet
// headers, read data and status snapshots; a monitor pops and compares them
// when the DUT presents a new head packet, read data, or a status request.
module tb_udp_rx_pkt_buffer;

    typedef struct {
        logic [15:0] len;
        logic [7:0]  words;
    } hdr_t;

    typedef struct {
        logic        avail;
        logic [31:0] cnt;
        logic [15:0] drop;
        logic [15:0] ovf;
        logic        busy;
        logic        chk_hdr;
        logic [15:0] len;
        logic [7:0]  words;
        logic        chk_rd;
        logic [31:0] rd;
    } stat_t;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_last;
    logic [15:0] in_len;
    logic        pkt_avail;
    logic [15:0] pkt_len;
    logic [7:0]  pkt_words;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data;
    logic        pkt_release;
    logic [31:0] pkt_count;
    logic [15:0] drop_count;
    logic [15:0] ovf_count;
    logic        busy;

    hdr_t        hdr_q [$];
    logic [31:0] rd_q  [$];
    stat_t       stat_q[$];

    logic rd_req   = 1'b0;
    logic stat_req = 1'b0;
    logic rd_req_q = 1'b0;
    logic rel_q    = 1'b0;
    logic clr_q    = 1'b0;

    int total = 0;
    int bad   = 0;

    udp_rx_pkt_buffer dut (
        .clk         (clk),
        .clr         (clr),
        .in_word     (in_word),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_len      (in_len),
        .pkt_avail   (pkt_avail),
        .pkt_len     (pkt_len),
        .pkt_words   (pkt_words),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pkt_release (pkt_release),
        .pkt_count   (pkt_count),
        .drop_count  (drop_count),
        .ovf_count   (ovf_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Remember what the DUT consumed at each rising edge.
    always @(posedge clk) begin
        rd_req_q <= rd_req;
        rel_q    <= pkt_release && pkt_avail && !clr;
        clr_q    <= clr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic missing(input string name);
        total++;
        bad++;
        $display("FAIL %s: DUT presented output but no expectation queued", name);
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    initial begin : monitor
        bit    head_checked;
        hdr_t  h;
        stat_t s;
        logic [31:0] r;
        head_checked = 1'b0;
        forever begin
            @(negedge clk);
            if (clr_q || rel_q) head_checked = 1'b0;
            if (pkt_avail && !head_checked) begin
                head_checked = 1'b1;
                if (hdr_q.size() == 0) missing("head_hdr");
                else begin
                    h = hdr_q.pop_front();
                    check("head_len", 32'(pkt_len), 32'(h.len));
                    check("head_words", 32'(pkt_words), 32'(h.words));
                end
            end
            if (rd_req_q) begin
                if (rd_q.size() == 0) missing("rd_data");
                else begin
                    r = rd_q.pop_front();
                    check("rd_data", rd_data, r);
                end
            end
            if (stat_req) begin
                if (stat_q.size() == 0) missing("status");
                else begin
                    s = stat_q.pop_front();
                    check("pkt_avail", 32'(pkt_avail), 32'(s.avail));
                    check("pkt_count", pkt_count, s.cnt);
                    check("drop_count", 32'(drop_count), 32'(s.drop));
                    check("ovf_count", 32'(ovf_count), 32'(s.ovf));
                    check("busy", 32'(busy), 32'(s.busy));
                    if (s.chk_hdr) begin
                        check("st_pkt_len", 32'(pkt_len), 32'(s.len));
                        check("st_pkt_words", 32'(pkt_words), 32'(s.words));
                    end
                    if (s.chk_rd) check("st_rd_data", rd_data, s.rd);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input int id, input int i);
        logic [7:0]  idb;
        logic [15:0] ib;
        if (id == 1) begin
            case (i)
                0:       return 32'hDEADBEEF;
                1:       return 32'h01020304;
                default: return 32'hA5B60000;
            endcase
        end
        idb = id[7:0];
        ib  = i[15:0];
        return {idb, 8'h5A, ib};
    endfunction

    task automatic send_pkt(input int id, input int n, input logic [15:0] len,
                            input bit last_alone, input bit rel_on_last);
        for (int i = 0; i < n; i++) begin
            in_valid    = 1'b1;
            in_word     = word_of(id, i);
            in_last     = (i == n - 1) && !last_alone;
            in_len      = len;
            pkt_release = rel_on_last && (i == n - 1) && !last_alone;
            tick();
        end
        if (last_alone) begin
            in_valid = 1'b0;
            in_last  = 1'b1;
            in_len   = len;
            tick();
        end
        in_valid    = 1'b0;
        in_last     = 1'b0;
        pkt_release = 1'b0;
    endtask

    task automatic push_hdr(input logic [15:0] len, input logic [7:0] words);
        hdr_t h;
        h.len   = len;
        h.words = words;
        hdr_q.push_back(h);
    endtask

    task automatic rd(input logic [6:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        rd_req  = 1'b1;
        rd_q.push_back(exp);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic release_head;
        pkt_release = 1'b1;
        tick();
        pkt_release = 1'b0;
    endtask

    task automatic exp_st(input logic avail, input int cnt, input int drop, input int ovf,
                          input logic bsy, input logic chk_hdr, input int len, input int words,
                          input logic chk_rd, input logic [31:0] rdv);
        stat_t s;
        s.avail   = avail;
        s.cnt     = cnt;
        s.drop    = drop[15:0];
        s.ovf     = ovf[15:0];
        s.busy    = bsy;
        s.chk_hdr = chk_hdr;
        s.len     = len[15:0];
        s.words   = words[7:0];
        s.chk_rd  = chk_rd;
        s.rd      = rdv;
        stat_q.push_back(s);
        stat_req = 1'b1;
        @(negedge clk);
        #1;
        stat_req = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        clr = 1'b1; in_word = '0; in_valid = 1'b0; in_last = 1'b0; in_len = '0;
        rd_addr = '0; pkt_release = 1'b0;
        tick(); tick();
        clr = 1'b0;
        exp_st(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0);

        // 10-byte packet: three words, then a separate in_last.
        push_hdr(16'd10, 8'd3);
        send_pkt(1, 3, 16'd10, 1'b1, 1'b0);
        exp_st(1, 1, 0, 0, 0, 1, 10, 3, 0, 32'h0);
        rd(7'd0, 32'hDEADBEEF);
        rd(7'd1, 32'h01020304);
        rd(7'd2, 32'hA5B60000);
        release_head();
        exp_st(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        // Three back-to-back packets: the third finds both banks occupied.
        push_hdr(16'd8, 8'd2);
        push_hdr(16'd13, 8'd4);
        send_pkt(2, 2, 16'd8, 1'b0, 1'b0);
        send_pkt(3, 4, 16'd13, 1'b0, 1'b0);
        send_pkt(4, 2, 16'd6, 1'b0, 1'b0);
        exp_st(1, 3, 1, 0, 0, 1, 8, 2, 0, 32'h0);
        rd(7'd1, word_of(2, 1));
        release_head();
        rd(7'd3, word_of(3, 3));
        release_head();
        exp_st(0, 3, 1, 0, 0, 0, 0, 0, 0, 32'h0);

        // 129 words overflow the bank; the next packet reuses that bank.
        send_pkt(5, 129, 16'd516, 1'b0, 1'b0);
        exp_st(0, 3, 1, 1, 0, 0, 0, 0, 0, 32'h0);
        push_hdr(16'd16, 8'd4);
        send_pkt(6, 4, 16'd16, 1'b0, 1'b0);
        exp_st(1, 4, 1, 1, 0, 1, 16, 4, 0, 32'h0);
        rd(7'd0, word_of(6, 0));
        rd(7'd3, word_of(6, 3));
        release_head();
        exp_st(0, 4, 1, 1, 0, 0, 0, 0, 0, 32'h0);

        // Single-word packet, then a bare in_last that must change nothing.
        push_hdr(16'd3, 8'd1);
        send_pkt(7, 1, 16'd3, 1'b0, 1'b0);
        exp_st(1, 5, 1, 1, 0, 1, 3, 1, 0, 32'h0);
        rd(7'd0, word_of(7, 0));
        in_last = 1'b1; in_len = 16'd99;
        tick();
        in_last = 1'b0;
        exp_st(1, 5, 1, 1, 0, 1, 3, 1, 0, 32'h0);

        // Release of bank 0 in the same cycle as the commit into bank 1.
        push_hdr(16'd7, 8'd2);
        send_pkt(8, 2, 16'd7, 1'b0, 1'b1);
        exp_st(1, 6, 1, 1, 0, 1, 7, 2, 0, 32'h0);
        rd(7'd1, word_of(8, 1));

        // clr in the middle of a fill with a committed packet held.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_word  = word_of(9, i);
            tick();
        end
        in_valid = 1'b0;
        exp_st(1, 6, 1, 1, 1, 0, 0, 0, 0, 32'h0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_st(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0);
        push_hdr(16'd12, 8'd3);
        send_pkt(10, 3, 16'd12, 1'b0, 1'b0);
        exp_st(1, 1, 0, 0, 0, 1, 12, 3, 0, 32'h0);
        rd(7'd2, word_of(10, 2));
        release_head();
        exp_st(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        tick(); tick(); tick();
        check("hdr_q_left", 32'(hdr_q.size()), 32'd0);
        check("rd_q_left", 32'(rd_q.size()), 32'd0);
        check("stat_q_left", 32'(stat_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udp_rx_pkt_buffer.md
# udp_rx_pkt_buffer

Ping-pong packet buffer directly downstream of the GMII UDP receive stage. It captures the receiver's 32-bit payload words into one of two banks and commits a bank only when the whole packet has arrived intact. Committed packets are presented in arrival order to the local consumer (CPU/scheduler) through a random-access read port with explicit release. Packets that overflow a bank, or that arrive while both banks are occupied, are discarded and counted.

## Interface
Parameters:
- `ADDR_W`, 7 — word address width per bank.
- `DEPTH`, 2**ADDR_W — words per bank (128 = 512 payload bytes).

Ports:
- `clk`  in  1  — GMII receive clock; the only clock.
- `clr`  in  1  — reset, synchronous, active-high.
- `in_word`  in  32  — payload word, big-endian byte order; the last word is zero-padded.
- `in_valid`  in  1  — one-cycle strobe per payload word.
- `in_last`  in  1  — one-cycle strobe marking end of packet; may coincide with the final `in_valid`.
- `in_len`  in  16  — UDP payload length in bytes; sampled on `in_last`.
- `pkt_avail`  out  1  — head bank holds a committed packet.
- `pkt_len`  out  16  — byte length of the head packet.
- `pkt_words`  out  ADDR_W+1  — number of words stored for the head packet.
- `rd_addr`  in  ADDR_W  — word address within the head bank.
- `rd_data`  out  32  — registered read data.
- `pkt_release`  in  1  — frees the head bank.
- `pkt_count`  out  32  — packets committed.
- `drop_count`  out  16  — packets dropped because no bank was free.
- `ovf_count`  out  16  — packets dropped because they exceeded `DEPTH`.
- `busy`  out  1  — write FSM is not in W_IDLE.

## Operation
- Per-bank state: `full[1:0]`, `len[b]`, `words[b]`. Pointers: `wr_sel` and `rd_sel`, both reset to 0. Each pointer toggles on its own commit or release, so packets are read in arrival order.
- Write FSM:
  - **W_IDLE**
    - `in_valid` while `!full[wr_sel]`: write the word at address 0, set `wcnt` = 1, go to W_FILL.
    - `in_valid` while `full[wr_sel]`: go to W_DROP and increment `drop_count`.
    - If `in_last` coincides with that first `in_valid`, the packet completes in the same cycle. It commits as a 1-word packet, or counts as a drop.
    - `in_last` without `in_valid` (zero-word packet): ignored, no counter changes.
  - **W_FILL**
    - `in_valid`: write at address `wcnt`, then increment `wcnt`.
    - If `wcnt` == `DEPTH` when `in_valid` arrives: do not write, increment `ovf_count`, go to W_DROP (or straight to W_IDLE if `in_last` is also high).
    - `in_last`: commit. Set `full[wr_sel]`, set `len` = `in_len`, set `words` = `wcnt` + (`in_valid` ? 1 : 0), toggle `wr_sel`, increment `pkt_count`, go to W_IDLE.
  - **W_DROP**
    - Discard all words. `in_last` returns the FSM to W_IDLE.
    - A bank freed during W_DROP does not rescue the current packet.
- Read side:
  - `pkt_avail` = `full[rd_sel]`; `pkt_len` = `len[rd_sel]`; `pkt_words` = `words[rd_sel]`.
  - `rd_data` returns the word at {`rd_sel`, `rd_addr`}. Data beyond `pkt_words` is stale and unspecified.
  - `pkt_release` while `pkt_avail`: clear `full[rd_sel]` and toggle `rd_sel`. `pkt_release` while `!pkt_avail` is ignored.
- Counters wrap modulo 2^width.

## Timing
- Reset values: all outputs 0; `full` = 0; both pointers 0; FSM in W_IDLE. `clr` mid-packet abandons the packet with no counter change, and all buffered packets are lost.
- Write-to-visible: `pkt_avail` rises one cycle after the `in_last` edge that commits into an empty head.
- Read latency: `rd_data` is valid one cycle after `rd_addr`. Reads stay valid only while the bank is held.
- Release: if the other bank is full, `pkt_avail` remains high and `pkt_len`/`pkt_words` switch to the next packet one cycle after `pkt_release`; otherwise `pkt_avail` falls one cycle after `pkt_release`.
- Commit and release in the same cycle always target different banks, and both take effect.
- Bank availability is checked only at the first word of a packet.

## Structure
- Shared package `udp_rx_buf_pkg` holds:
  - the write-FSM state encoding (W_IDLE/W_FILL/W_DROP);
  - the default `ADDR_W`;
  - the counter widths.
- One sub-module, `udp_buf_ram`: simple dual-port RAM of 2·`DEPTH`×32, one write port and one registered read port, addressed by {bank, word}. Infers block RAM.

## Test plan
- 10-byte packet: 3 words + `in_last` with `in_len` = 10 → one cycle later `pkt_avail` = 1, `pkt_len` = 10, `pkt_words` = 3; reads of addresses 0–2 return the written words with last-byte padding intact; `pkt_count` = 1.
- Three packets back-to-back, no release → first two are committed, third raises `drop_count` = 1; releasing twice returns packets in order 1, 2, then `pkt_avail` = 0.
- 129-word packet with `ADDR_W` = 7 → `ovf_count` = 1; the bank is not committed; the next 4-word packet commits into the same bank.
- Single word with `in_valid` and `in_last` in the same cycle → `pkt_words` = 1; `in_last` alone in W_IDLE → no change anywhere.
- Release of bank 0 in the same cycle as commit into bank 1 → `pkt_avail` stays 1 and `pkt_len` switches to packet 2 the next cycle.
- `clr` asserted mid-W_FILL with one packet already committed → every output is 0 the next cycle; a following packet commits into bank 0.
